des_round_ctrl: RTL and testbench

// - Sequencing controller for the iterative DES core: IP load -> 16 Feistel rounds -> FP/output.
// - Accepts one 64-bit block job per valid/ready handshake and drives the round-register

---
 rtl/des_round_ctrl.sv | 118 +++++++++++
 tb/tb_des_round_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencing controller for an iterative DES core.
// Walks IDLE -> LOAD -> 16 x ROUND -> DONE and drives the datapath strobes:
// ld, round_en, round index, and the key-schedule rotate amount and direction.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// Valid is never withdrawn before the transfer, except on flush or reset.
module des_round_ctrl #(
  parameter int ROUNDS    = 16,
  parameter bit BACK2BACK = 1'b1,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic                 in_decrypt_i,
  output logic                 in_ready_o,
  output logic                 ld_o,
  output logic                 round_en_o,
  output logic [3:0]           round_o,
  output logic [1:0]           key_shift_o,
  output logic                 key_dir_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic [BLK_CNT_W-1:0] blk_cnt_o,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t                 state, state_nxt;
  logic [3:0]             rcnt;
  logic                   mode;
  logic [BLK_CNT_W-1:0]   blk_cnt;
  logic                   accept;
  logic                   hand_off;

  // A job is taken only when ready is shown; the result leaves on out_ready in DONE.
  assign accept   = in_ready_o & in_valid_i;
  assign hand_off = (state == S_DONE) & out_ready_i & ~flush_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid_i) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_ROUND;
        S_ROUND: if (rcnt == LAST_ROUND) state_nxt = S_DONE;
        S_DONE: begin
          if (out_ready_i) state_nxt = (in_valid_i && BACK2BACK) ? S_LOAD : S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Round counter runs only while in ROUND and is cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          rcnt <= 4'd0;
    else if (flush_i || state != S_ROUND || rcnt == LAST_ROUND) rcnt <= 4'd0;
    else                                                 rcnt <= rcnt + 4'd1;
  end

  // Job mode is captured at accept and ignored for the rest of the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mode <= 1'b0;
    else if (accept) mode <= in_decrypt_i;
  end

  // Completed-block counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        blk_cnt <= '0;
    else if (hand_off) blk_cnt <= blk_cnt + {{(BLK_CNT_W-1){1'b0}}, 1'b1};
  end

  // Output decode from the current state and round index.
  always_comb begin
    in_ready_o  = ~flush_i & ((state == S_IDLE) |
                  ((state == S_DONE) & out_ready_i & BACK2BACK));
    ld_o        = (state == S_LOAD);
    round_en_o  = (state == S_ROUND);
    out_valid_o = (state == S_DONE);
    busy_o      = (state != S_IDLE);
    round_o     = 4'd0;
    key_shift_o = 2'd0;
    key_dir_o   = 1'b0;
    if (state == S_ROUND) begin
      round_o   = rcnt;
      key_dir_o = mode;
      // Decrypt starts from the encrypt end state, so its first round needs no rotate.
      case (rcnt)
        4'd0:                key_shift_o = mode ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15:   key_shift_o = 2'd1;
        default:             key_shift_o = 2'd2;
      endcase
    end
  end

  assign blk_cnt_o = blk_cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: directed table jobs, random jobs against a
// transaction-level model, flush/reset disturbances, and a narrow-counter
// instance without back-to-back for wrap and IDLE-gap behaviour.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b0;
  logic        in_ready, ld, round_en, key_dir, out_valid, busy;
  logic [3:0]  rnd;
  logic [1:0]  key_shift, dbg_state;
  logic [15:0] blk_cnt;

  logic        flush1 = 1'b0, in_valid1 = 1'b0, in_decrypt1 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready1, ld1, round_en1, key_dir1, out_valid1, busy1;
  logic [3:0]  rnd1;
  logic [1:0]  key_shift1, dbg_state1;
  logic [3:0]  blk_cnt1;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  typedef struct {
    bit         dec;
    int         rnd;
    logic [1:0] shift;
    logic       dir;
  } vec_t;
  vec_t tbl[32];

  // clock
  always #5 clk = ~clk;

  des_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_decrypt_i(in_decrypt), .in_ready_o(in_ready), .ld_o(ld),
    .round_en_o(round_en), .round_o(rnd), .key_shift_o(key_shift),
    .key_dir_o(key_dir), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .blk_cnt_o(blk_cnt), .dbg_state(dbg_state)
  );

  des_round_ctrl #(.ROUNDS(16), .BACK2BACK(1'b0), .BLK_CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush1), .in_valid_i(in_valid1),
    .in_decrypt_i(in_decrypt1), .in_ready_o(in_ready1), .ld_o(ld1),
    .round_en_o(round_en1), .round_o(rnd1), .key_shift_o(key_shift1),
    .key_dir_o(key_dir1), .out_valid_o(out_valid1), .out_ready_i(out_ready1),
    .busy_o(busy1), .blk_cnt_o(blk_cnt1), .dbg_state(dbg_state1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key rotate rule: one position at rounds 0,1,8,15, two otherwise; decrypt skips round 0.
  function automatic logic [1:0] model_shift(input bit dec, input int k);
    if (dec && k == 0) return 2'd0;
    if (k == 0 || k == 1 || k == 8 || k == 15) return 2'd1;
    return 2'd2;
  endfunction

  // One full job on dut. Positioned at a falling edge; inputs change there and
  // outputs are checked 1 time unit later. chained: job already accepted in the
  // previous release cycle. b2b_next/next_dec: request presented at release.
  task automatic run_job(input bit dec, input int delay, input bit chained,
                         input bit b2b_next, input bit next_dec,
                         input bit use_tbl, input bit toggle);
    logic [1:0] es;
    if (!chained) begin
      @(negedge clk); in_valid = 1'b1; in_decrypt = dec; out_ready = 1'b0; #1;
      chk("idle_ready", in_ready, 1); chk("idle_busy", busy, 0);
      chk("idle_cnt", blk_cnt, exp_cnt);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    if (toggle) in_decrypt = ~dec;
    #1;
    chk("ld", ld, 1); chk("ld_busy", busy, 1); chk("ld_round_en", round_en, 0);
    chk("ld_ready", in_ready, 0); chk("ld_cnt", blk_cnt, exp_cnt);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (toggle) in_decrypt = 1'($urandom_range(0, 1));
      #1;
      es = use_tbl ? tbl[(dec ? 16 : 0) + k].shift : model_shift(dec, k);
      chk("round_en", round_en, 1); chk("round_idx", rnd, k);
      chk("key_shift", key_shift, es); chk("key_dir", key_dir, dec);
      chk("round_ld", ld, 0); chk("round_out_valid", out_valid, 0);
    end
    for (int d = 0; d < delay; d++) begin
      @(negedge clk); out_ready = 1'b0; in_valid = 1'($urandom_range(0, 1)); #1;
      chk("hold_valid", out_valid, 1); chk("hold_ready", in_ready, 0);
      chk("hold_cnt", blk_cnt, exp_cnt); chk("hold_ld", ld, 0);
    end
    @(negedge clk); out_ready = 1'b1; in_valid = b2b_next; in_decrypt = next_dec; #1;
    chk("done_valid", out_valid, 1); chk("done_ready_b2b", in_ready, 1);
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
  endtask

  // Accept a job on dut and advance n falling edges past the accept cycle.
  task automatic go_to(input bit dec, input int n);
    @(negedge clk); in_valid = 1'b1; in_decrypt = dec; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
    #1;
  endtask

  initial begin
    int enc_sh[16];
    int dec_sh[16];
    bit ch, d, nd, b2b;
    int waited;

    enc_sh = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    dec_sh = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    for (int k = 0; k < 16; k++) begin
      tbl[k]      = '{dec: 1'b0, rnd: k, shift: 2'(enc_sh[k]), dir: 1'b0};
      tbl[16 + k] = '{dec: 1'b1, rnd: k, shift: 2'(dec_sh[k]), dir: 1'b1};
    end

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ld", ld, 0); chk("rst_round_en", round_en, 0); chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_cnt", blk_cnt, 0);
    chk("rst_shift", key_shift, 0); chk("rst_dir", key_dir, 0); chk("rst_round", rnd, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_ready", in_ready, 1);

    // narrow counter, no back-to-back: IDLE gap each job and wrap after 16
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      waited = 0;
      do begin
        @(negedge clk); #1; waited++;
      end while (!out_valid1 && waited < 30);
      chk("nob2b_timeout", {31'd0, out_valid1}, 1);
      chk("nob2b_ready_in_done", in_ready1, 0);
      @(negedge clk); #1;
      chk("nob2b_gap_ld", ld1, 0); chk("nob2b_gap_ready", in_ready1, 1);
      chk("nob2b_gap_busy", busy1, 0); chk("wrap_cnt", blk_cnt1, j % 16);
    end
    in_valid1 = 1'b0; out_ready1 = 1'b0;

    // table-driven directed jobs: encrypt, decrypt held 10 cycles, chained encrypt
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job(1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_job(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // random jobs with mode toggling, random stalls and random back-to-back
    ch = 1'b0;
    d = 1'($urandom_range(0, 1));
    for (int i = 0; i < 20; i++) begin
      nd  = 1'($urandom_range(0, 1));
      b2b = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_job(d, $urandom_range(0, 4), ch, b2b, nd, 1'b0, 1'b1);
      ch = b2b; d = nd;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("post_idle_busy", busy, 0); chk("post_cnt", blk_cnt, exp_cnt);

    // flush at round 7, with a request present that must not be taken
    go_to(1'b1, 9);
    chk("pre_flush_round", rnd, 7);
    flush = 1'b1; in_valid = 1'b1; #1;
    chk("flush_ready", in_ready, 0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_busy", busy, 0); chk("flush_round_en", round_en, 0);
    chk("flush_ready_after", in_ready, 1); chk("flush_cnt", blk_cnt, exp_cnt);
    @(negedge clk); #1;
    chk("flush_no_accept", busy, 0);

    // flush in DONE: result dropped, counter unchanged
    go_to(1'b0, 18);
    chk("pre_flush_done", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; #1;
    chk("flush_done_ready", in_ready, 0);
    @(negedge clk); flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0; #1;
    chk("flush_done_valid", out_valid, 0); chk("flush_done_busy", busy, 0);
    chk("flush_done_cnt", blk_cnt, exp_cnt);

    // asynchronous reset at round 7
    go_to(1'b1, 9);
    chk("pre_rst_round", rnd, 7);
    rst_n = 1'b0; #1;
    chk("arst_round_en", round_en, 0); chk("arst_round", rnd, 0);
    chk("arst_busy", busy, 0); chk("arst_shift", key_shift, 0);
    chk("arst_dir", key_dir, 0); chk("arst_cnt", blk_cnt, 0);
    chk("arst_out_valid", out_valid, 0); chk("arst_ld", ld, 0);
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("arst_ready", in_ready, 1);
    run_job(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); out_ready = 1'b0; #1;
    chk("final_cnt", blk_cnt, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
